ysyx_041461_pipe_stage_reg: RTL
===============================

# ysyx_041461_pipe_stage_reg

Parametrised pipeline stage register for the ysyx_041461 core, the successor to the fixed-field per-stage registers. It carries an opaque payload of configurable width between two pipeline stages using a valid/ready handshake, replacing the global enable line. Per-transfer kill and whole-stage flush inputs are provided, and an optional skid slot gives full throughput with a registered `in_ready`. It is instantiated between IF/ID/EXE/MEM/WB, with the payload built by concatenating that stage's fields.

## Interface
Parameters:
- `DATA_W`, 64: payload width in bits, valid range 1–512.
- `RESET_DATA`, `{DATA_W{1'b0}}`: reset value of `out_data`. The MEM/WB instances place 64'h0000_0000_8000_0000 in the PC field.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset is asynchronous and active-low (state reset while `rst`==0).
- `flush`, input, 1: kill every transaction held in the stage (branch, exception or trap redirect).
- `in_valid`, input, 1: upstream offers a transaction.
- `in_kill`, input, 1: the offered transaction is consumed but discarded (hazard-control bubble).
- `in_data`, input, DATA_W: upstream payload.
- `in_ready`, output, 1: the stage accepts this cycle.
- `out_valid`, output, 1: downstream transaction present.
- `out_ready`, input, 1: downstream consumes this cycle.
- `out_data`, output, DATA_W: downstream payload.

## Operation
- Accept = `in_valid & in_ready`. Deliver = `out_valid & out_ready`.
- A transfer that is accepted with `in_kill`=1 completes the handshake but never appears at the output.
- Data registers load only when a non-killed transfer is accepted. A bubble leaves `out_data` unchanged.
- `flush`=1 in a cycle:
  - all stored valid bits clear on the next edge;
  - any transfer accepted in that cycle is discarded;
  - data registers are not modified;
  - `flush` takes priority over accept and over the skid-to-main move.
- Ordering is strictly FIFO; no transaction is ever duplicated or reordered.
- Reset values: `out_valid`=0, `out_data`=`RESET_DATA`, `in_ready`=1, skid valid=0, skid data=`RESET_DATA`.

## Timing
- Latency is 1 cycle: a transaction accepted at edge N is visible on `out_*` after edge N.
- Without skid:
  - `in_ready = !out_valid | out_ready` (combinational from `out_ready`);
  - back-to-back throughput of 1 per cycle.
- With skid:
  - `in_ready = !skid_valid`, taken directly from a flop.
  - Main slot empty, or delivering with no skid entry: the accepted transfer goes to main.
  - Main slot holding and `out_ready`=0: the accepted transfer goes to skid.
  - Deliver while skid is valid: skid moves to main on the same edge, skid clears, and a simultaneous accept goes to main is not allowed (`in_ready`=0 that cycle).
  - Full state (main and skid both valid): `in_ready`=0 until a deliver occurs.
- An asynchronous reset asserted mid-transfer drops every held transaction immediately, with no glitch dependency on `clk`.
- `in_kill` and `flush` asserted together: the flush behaviour applies.

## Configuration
- Macro: `YSYX_041461_PIPE_SKID_EN`.
- Defined: a two-entry (main + skid) stage with registered `in_ready`, which breaks the combinational ready chain across stages.
- Undefined: a single entry with combinational `in_ready`, the skid registers absent, and fewer flops.
- Interface, latency and flush/kill semantics are identical in both builds.

## Structure
- The shared defines header holds the reset constants (`ysyx_041461_PC_RESET`) and the per-stage payload field widths and offsets. It also holds the NOP encodings (`exception_NOP`, `MEM_NOP`, `WB_NOP`) that callers pack into `RESET_DATA`.
- The natural sub-module is `ysyx_041461_pipe_slot`: one valid+data entry with load, clear and async active-low reset. Main and skid are two instances of it.

## Test plan
- **Reset:** release `rst` with `DATA_W`=64 and `RESET_DATA`=64'h8000_0000. Required: `out_valid`=0, `out_data`=64'h8000_0000, `in_ready`=1.
- **Streaming:** drive 8 transfers 0x10..0x17 with `out_ready`=1 throughout. Required: outputs 0x10..0x17 on consecutive cycles, 1 cycle after the matching input.
- **Backpressure:** hold `out_ready`=0 after 0x20 and 0x21 are offered. Required:
  - skid build: 0x20 held at the output, 0x21 stored in skid, `in_ready`=0;
  - raising `out_ready` delivers 0x20 then 0x21 with no loss.
- **Kill:** offer 0x33 with `in_kill`=1. Required: the handshake completes, `out_valid`=0 next cycle, and `out_data` keeps its previous value.
- **Flush with both entries full:** assert `flush` while offering 0x44. Required: next cycle `out_valid`=0, skid empty, `in_ready`=1, and 0x44 never delivered.
- **Mid-stream reset:** assert `rst`=0 asynchronously between clock edges while the stage is full. Required: `out_valid` drops to 0 immediately and `out_data` returns to `RESET_DATA`.

Source files
------------

// File: rtl/ysyx_041461_pipe_stage_reg_pkg.sv
// Shared definitions for the ysyx_041461 pipeline stage registers.
// Holds the reset constants, the per-stage payload field layout, and the
// NOP encodings that callers pack into RESET_DATA. Also provides the
// handshake helper that the stage register uses.
package ysyx_041461_pipe_stage_reg_pkg;

  // Reset PC of the core; MEM/WB instances place it in their PC field.
  localparam logic [63:0] ysyx_041461_PC_RESET = 64'h0000_0000_8000_0000;

  // Per-stage payload field widths.
  localparam int unsigned PC_W   = 32'd64;
  localparam int unsigned INST_W = 32'd32;
  localparam int unsigned EXC_W  = 32'd8;
  localparam int unsigned MEM_W  = 32'd8;
  localparam int unsigned WB_W   = 32'd8;

  // Per-stage payload field offsets (LSB position inside the payload).
  localparam int unsigned IFID_PC_OFF   = 32'd0;
  localparam int unsigned IFID_INST_OFF = IFID_PC_OFF + PC_W;
  localparam int unsigned IFID_W        = IFID_INST_OFF + INST_W;

  // NOP encodings: no exception, no memory access, no register write-back.
  localparam logic [EXC_W-1:0] exception_NOP = 8'h00;
  localparam logic [MEM_W-1:0] MEM_NOP       = 8'h00;
  localparam logic [WB_W-1:0]  WB_NOP        = 8'h00;

  // Pipeline stage identifiers, used when naming stage register instances.
  typedef enum logic [2:0] {
    STAGE_IF  = 3'd0,
    STAGE_ID  = 3'd1,
    STAGE_EXE = 3'd2,
    STAGE_MEM = 3'd3,
    STAGE_WB  = 3'd4
  } stage_e;

  // A handshake fires when both sides agree in the same cycle.
  function automatic logic pipe_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/ysyx_041461_pipe_stage_reg_if.sv
// Valid/ready channel between two pipeline stages.
// The master drives valid/kill/data and observes ready; the slave is the
// receiving side. kill marks an offered transfer as a bubble.
interface ysyx_041461_pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 32'd64
);
  logic              valid;
  logic              ready;
  logic              kill;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output kill,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  kill,
    input  data,
    output ready
  );
endinterface

// File: rtl/ysyx_041461_pipe_slot.sv
// One valid+data storage entry of a pipeline stage register.
// clr wins over load and only drops the valid bit; data is written only by
// a load, so a cleared entry keeps its last payload.
module ysyx_041461_pipe_slot #(
  parameter int unsigned       DATA_W     = 32'd64,
  parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Valid flag: cleared by clr, set by load, otherwise held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload: captured only on a load that is not being cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= RESET_DATA;
    end else if (load && !clr) begin
      data <= d;
    end
  end

endmodule

// File: rtl/ysyx_041461_pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with kill and flush.
// Build option YSYX_041461_PIPE_SKID_EN: when defined, a skid entry is added
// behind the main entry so in_ready comes straight from a flop and the
// combinational ready chain between stages is broken. When undefined, the
// stage is a single entry with in_ready = !out_valid | out_ready.
// Latency is one cycle in both builds.
module ysyx_041461_pipe_stage_reg
  import ysyx_041461_pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32'd64,
  parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  ysyx_041461_pipe_stage_reg_if.slave   up,
  ysyx_041461_pipe_stage_reg_if.master  dn
);

  logic              in_ready;
  logic              accept;
  logic              load;
  logic              deliver;
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              main_load;
  logic              main_clr;
  logic [DATA_W-1:0] main_d;

`ifdef YSYX_041461_PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              skid_clr;

  // Registered ready: the stage takes a new transfer whenever skid is free.
  assign in_ready = !skid_valid;
`else
  // Single entry: free slot, or the held entry leaves this same cycle.
  assign in_ready = !main_valid | dn.ready;
`endif

  assign accept  = pipe_fire(up.valid, in_ready);
  // A killed or flushed accept completes the handshake but stores nothing.
  assign load    = accept & !up.kill & !flush;
  assign deliver = pipe_fire(main_valid, dn.ready);

  // Slot steering: route loads to main or skid, move skid to main on
  // deliver, and let flush clear every valid bit ahead of anything else.
  always_comb begin
    main_load = 1'b0;
    main_d    = up.data;
`ifdef YSYX_041461_PIPE_SKID_EN
    skid_load = 1'b0;
    skid_clr  = flush;
    if (skid_valid) begin
      // in_ready is low here, so no new transfer competes with the move.
      main_load = deliver & !flush;
      main_d    = skid_data;
      skid_clr  = flush | deliver;
    end else begin
      main_load = load & (!main_valid | deliver);
      skid_load = load & main_valid & !deliver;
    end
`else
    main_load = load;
`endif
    main_clr = flush | (deliver & !main_load);
  end

  ysyx_041461_pipe_slot #(
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clr   (main_clr),
    .d     (main_d),
    .valid (main_valid),
    .data  (main_data)
  );

`ifdef YSYX_041461_PIPE_SKID_EN
  ysyx_041461_pipe_slot #(
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clr   (skid_clr),
    .d     (up.data),
    .valid (skid_valid),
    .data  (skid_data)
  );
`endif

  assign up.ready = in_ready;
  assign dn.valid = main_valid;
  assign dn.data  = main_data;
  assign dn.kill  = 1'b0;

endmodule
